fft_stage_sequencer: RTL

- Controller that sequences an in-place radix-2 DIT FFT of N = 2^LOG2_N points over a single pipelined butterfly datapath and shared sample RAM.
- Walks all stages and butterflies, issuing per butterfly:
  - the two RAM operand addresses
  - the twiddle ROM index
- Inserts a pipeline drain between stages to avoid read-after-write hazards, then signals completion.
- Sits between the top-level FFT control FSM (start/done) and the butterfly/RAM/twiddle datapath.

---
 rtl/fft_stage_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fft_stage_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT over one pipelined butterfly.
// Optional bit-reversed unload phase enabled by FFT_STAGE_SEQUENCER_BITREV_EN.
module fft_stage_sequencer #(
    parameter int LOG2_N     = 6,
    parameter int PIPE_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        bf_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        bf_valid,
    output logic [LOG2_N-1:0]           addr_a,
    output logic [LOG2_N-1:0]           addr_b,
    output logic [LOG2_N-2:0]           tw_idx,
    output logic [$clog2(LOG2_N)-1:0]   stage,
    output logic                        stage_last_bf
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
    ,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [LOG2_N-1:0]           rd_addr
`endif
);

    localparam int SW = $clog2(LOG2_N);
    localparam int KW = LOG2_N - 1;
    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(LOG2_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
        , S_UNLOAD
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            finish_stage;
    logic            xfer;
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
    logic [LOG2_N-1:0] j_q, j_d;
`endif

    assign bf_valid = (state_q == S_RUN);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign stage    = stage_q;
    assign xfer     = bf_valid && bf_ready;

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        k_d          = k_q;
        drain_d      = drain_q;
        finish_stage = 1'b0;
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
        j_d          = j_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (PIPE_DEPTH == 0) begin
                            finish_stage = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (int'(drain_q) == PIPE_DEPTH - 1) begin
                    finish_stage = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stage_d = '0;
            end
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
            S_UNLOAD: begin
                if (rd_ready) begin
                    j_d = j_q + LOG2_N'(1);
                    if (j_q == {LOG2_N{1'b1}}) begin
                        state_d = S_DONE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Shared tail of a stage: reached from DRAIN, or straight from RUN when there is no drain.
        if (finish_stage) begin
            drain_d = '0;
            if (stage_q == S_LAST) begin
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
                state_d = S_UNLOAD;
                j_d     = '0;
`else
                state_d = S_DONE;
`endif
            end else begin
                state_d = S_RUN;
                stage_d = stage_q + SW'(1);
            end
        end

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            stage_d = '0;
            k_d     = '0;
            drain_d = '0;
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
            j_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            drain_q <= '0;
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
            j_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            drain_q <= drain_d;
`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
            j_q     <= j_d;
`endif
        end
    end

    logic [LOG2_N-1:0] k_ext, span, pos, a_raw;
    logic [SW-1:0]     tw_sh;

    always_comb begin
        k_ext  = {1'b0, k_q};
        span   = LOG2_N'(1) << stage_q;
        pos    = k_ext & (span - LOG2_N'(1));
        a_raw  = (((k_ext >> stage_q) << stage_q) << 1) | pos;
        tw_sh  = S_LAST - stage_q;
        addr_a = '0;
        addr_b = '0;
        tw_idx = '0;
        // Addresses are forced to zero whenever no butterfly is offered.
        if (bf_valid) begin
            addr_a = a_raw;
            addr_b = a_raw + span;
            tw_idx = KW'(pos) << tw_sh;
        end
    end

    assign stage_last_bf = bf_valid && (k_q == K_LAST);

`ifdef FFT_STAGE_SEQUENCER_BITREV_EN
    assign rd_valid = (state_q == S_UNLOAD);

    always_comb begin
        rd_addr = '0;
        if (rd_valid) begin
            for (int i = 0; i < LOG2_N; i++) begin
                rd_addr[i] = j_q[LOG2_N-1-i];
            end
        end
    end
`endif

endmodule
